// File: rtl/wb_arbiter.sv
// wb_arbiter
// Write-back stage in front of the register file. Merges the ALU (source 0)
// and LSU (source 1) result streams into one write-back stream, which also
// feeds RF-stage forwarding. Sources are picked round-robin when both are
// valid, and the winner is held in a one-entry output register. Every
// write-back handshake counts as one retired instruction (minstret_o).
//
// Build option: define WB_PERF_CNT_EN to add the per-source write-back
// counters and the conflict counter (alu_wb_cnt_o, lsu_wb_cnt_o,
// conflict_cnt_o). Without it those ports and registers are absent and the
// block behaves identically otherwise.

package wb_arbiter_pkg;

    // Write-back payload: destination register and the value to write.
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] wdata;
    } wbrf_tdata_t;

    // Result source index, also the encoding of the round-robin pointer.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

endpackage

module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC   = 2,
    parameter int unsigned CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,

    // ALU result stream (source 0)
    input  logic                 alwb_tvalid_i,
    output logic                 alwb_tready_o,
    input  wbrf_tdata_t          alwb_tdata_i,

    // LSU result stream (source 1)
    input  logic                 lswb_tvalid_i,
    output logic                 lswb_tready_o,
    input  wbrf_tdata_t          lswb_tdata_i,

    // Write-back stream to the register file and forwarding path
    output logic                 wbrf_tvalid_o,
    input  logic                 wbrf_tready_i,
    output wbrf_tdata_t          wbrf_tdata_o,

    // Retired-instruction count
    output logic [CNT_WIDTH-1:0] minstret_o
`ifdef WB_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] alu_wb_cnt_o,
    output logic [CNT_WIDTH-1:0] lsu_wb_cnt_o,
    output logic [CNT_WIDTH-1:0] conflict_cnt_o
`endif
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                 out_v_q,    out_v_d;
    wbrf_tdata_t          out_d_q,    out_d_d;
    src_e                 rr_q,       rr_d;
    logic [CNT_WIDTH-1:0] minstret_q, minstret_d;

    // ------------------------------------------------------------------
    // Arbitration signals
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0]   src_valid;
    logic                 both_valid;
    logic                 any_valid;
    logic                 can_load;
    src_e                 gnt_idx;
    wbrf_tdata_t          gnt_data;
    logic                 take;
    logic                 wbrf_fire;

    assign src_valid  = {lswb_tvalid_i, alwb_tvalid_i};
    assign both_valid = &src_valid;
    assign any_valid  = |src_valid;

    assign wbrf_tvalid_o = out_v_q;
    assign wbrf_tdata_o  = out_d_q;
    assign minstret_o    = minstret_q;

    // Grant selection, source handshakes and next state of the output stage.
    // NOTE: every variable gets a default at the top of a combinational block;
    // any path that left one unassigned would infer a latch.
    always_comb begin
        can_load      = !out_v_q || wbrf_tready_i;
        wbrf_fire     = out_v_q && wbrf_tready_i;

        // A lone valid source wins; on conflict the pointer decides.
        gnt_idx       = SRC_ALU;
        if (both_valid) begin
            gnt_idx = rr_q;
        end else if (src_valid[SRC_LSU]) begin
            gnt_idx = SRC_LSU;
        end

        gnt_data      = (gnt_idx == SRC_LSU) ? lswb_tdata_i : alwb_tdata_i;

        // No source is accepted while reset is asserted, so an item offered
        // during reset is still there afterwards.
        take          = rst && any_valid && can_load;
        alwb_tready_o = take && (gnt_idx == SRC_ALU);
        lswb_tready_o = take && (gnt_idx == SRC_LSU);

        out_v_d       = out_v_q;
        out_d_d       = out_d_q;
        rr_d          = rr_q;

        if (take) begin
            // Fill (possibly while the old entry drains in the same cycle).
            out_v_d = 1'b1;
            out_d_d = gnt_data;
            // Only a contested grant moves the pointer, to the loser.
            if (both_valid) begin
                rr_d = src_e'(~gnt_idx);
            end
        end else if (wbrf_tready_i) begin
            // Drain with nothing to reload.
            out_v_d = 1'b0;
        end

        minstret_d    = minstret_q + CNT_WIDTH'(wbrf_fire);
    end

    // Output register and round-robin pointer.
    // NOTE: rst is synchronous here, so it is sampled only at the clock edge
    // and stays out of the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the data register is reset too because its reset value
            // is visible on wbrf_tdata_o; a pure datapath register could skip it.
            out_v_q <= 1'b0;
            out_d_q <= '0;
            rr_q    <= SRC_ALU;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // the pre-edge values computed by the combinational block.
            out_v_q <= out_v_d;
            out_d_q <= out_d_d;
            rr_q    <= rr_d;
        end
    end

    // Retire counter: one count per write-back handshake, wrapping freely.
    always_ff @(posedge clk) begin
        if (!rst) begin
            minstret_q <= '0;
        end else begin
            minstret_q <= minstret_d;
        end
    end

`ifdef WB_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] alu_cnt_q,  alu_cnt_d;
    logic [CNT_WIDTH-1:0] lsu_cnt_q,  lsu_cnt_d;
    logic [CNT_WIDTH-1:0] conf_cnt_q, conf_cnt_d;

    assign alu_wb_cnt_o   = alu_cnt_q;
    assign lsu_wb_cnt_o   = lsu_cnt_q;
    assign conflict_cnt_o = conf_cnt_q;

    // Per-source handshake counts and cycles where both sources competed.
    always_comb begin
        alu_cnt_d  = alu_cnt_q  + CNT_WIDTH'(alwb_tvalid_i && alwb_tready_o);
        lsu_cnt_d  = lsu_cnt_q  + CNT_WIDTH'(lswb_tvalid_i && lswb_tready_o);
        conf_cnt_d = conf_cnt_q + CNT_WIDTH'(both_valid && can_load);
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            alu_cnt_q  <= '0;
            lsu_cnt_q  <= '0;
            conf_cnt_q <= '0;
        end else begin
            alu_cnt_q  <= alu_cnt_d;
            lsu_cnt_q  <= lsu_cnt_d;
            conf_cnt_q <= conf_cnt_d;
        end
    end
`else
    // Performance counters not built.
`endif

endmodule
